cla_pipe_adder: RTL and testbench

//  Parametrised, 2-stage pipelined carry-lookahead adder/subtractor; successor to the fixed 32-bit 74882 CLA model.
//  Per-bit P/G are built internally; group P/G feed a generic lookahead tree.

---
 rtl/cla_pkg.sv | 30 +++
 rtl/cla_lookahead_tree.sv | 29 ++
 rtl/cla_pipe_adder.sv | 164 ++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared defaults and helpers for the pipelined carry-lookahead adder.
// group_pg folds per-bit propagate/generate into one 74181-style slice.
package cla_pkg;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefGroup = 4;
    localparam int unsigned MaxGroup = 32;

    function automatic int unsigned ngrp(input int unsigned width, input int unsigned group);
        return width / group;
    endfunction

    // Returns {P, G} of a group of n bits. Bits at or above n are ignored.
    function automatic logic [1:0] group_pg(input logic [MaxGroup-1:0] p,
                                            input logic [MaxGroup-1:0] g,
                                            input int unsigned n);
        logic gp;
        logic gg;
        gp = 1'b1;
        gg = 1'b0;
        for (int unsigned i = 0; i < MaxGroup; i++) begin
            if (i < n) begin
                gg = g[i] | (p[i] & gg);
                gp = gp & p[i];
            end
        end
        return {gp, gg};
    endfunction

endpackage

// File: rtl/cla_lookahead_tree.sv
// Generic 74882-style lookahead unit: every group carry is a flat
// sum-of-products of group P/G terms and the incoming carry.
module cla_lookahead_tree #(
    parameter int unsigned NGRP = 8
) (
    input  logic [NGRP-1:0] p,
    input  logic [NGRP-1:0] g,
    input  logic            cin,
    output logic [NGRP-1:0] c
);

    always_comb begin
        logic term;
        logic pp;
        c    = '0;
        term = 1'b0;
        pp   = 1'b0;
        for (int k = 0; k < int'(NGRP); k++) begin
            term = g[k];
            pp   = p[k];
            for (int j = k - 1; j >= 0; j--) begin
                term = term | (pp & g[j]);
                pp   = pp & p[j];
            end
            c[k] = term | (pp & cin);
        end
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// handshakes and a carry register for extended-precision word chains.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned GROUP = DefGroup,
    localparam int unsigned NGRP = ngrp(WIDTH, GROUP)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    input  logic             in_chain,
    input  logic             clr_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [NGRP-1:0]  out_gc
);

    if (WIDTH % GROUP != 0) begin : g_width_check
        $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
    end
    if (GROUP > MaxGroup) begin : g_group_check
        $error("cla_pipe_adder: GROUP exceeds MaxGroup");
    end

    logic s1_en, s2_en;

    // Stage-1 combinational: operand conditioning and per-bit / per-group P,G
    logic [WIDTH-1:0] b_in, p_in, g_in;
    logic [NGRP-1:0]  gp_in, gg_in;

    assign b_in = in_b ^ {WIDTH{in_sub}};
    assign p_in = in_a | b_in;
    assign g_in = in_a & b_in;

    always_comb begin
        logic [MaxGroup-1:0] pv;
        logic [MaxGroup-1:0] gv;
        logic [1:0]          pg;
        gp_in = '0;
        gg_in = '0;
        pv    = '0;
        gv    = '0;
        pg    = '0;
        for (int unsigned k = 0; k < NGRP; k++) begin
            pv            = '0;
            gv            = '0;
            pv[GROUP-1:0] = p_in[k*GROUP +: GROUP];
            gv[GROUP-1:0] = g_in[k*GROUP +: GROUP];
            pg            = group_pg(pv, gv, GROUP);
            gp_in[k]      = pg[1];
            gg_in[k]      = pg[0];
        end
    end

    logic             s1_valid, s1_sub, s1_cin, s1_chain;
    logic [WIDTH-1:0] s1_a, s1_b, s1_p, s1_g;
    logic [NGRP-1:0]  s1_gp, s1_gg;
    logic             carry_reg;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sub   <= 1'b0;
            s1_cin   <= 1'b0;
            s1_chain <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_gp    <= '0;
            s1_gg    <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sub   <= in_sub;
                s1_cin   <= in_cin;
                s1_chain <= in_chain;
                s1_a     <= in_a;
                s1_b     <= b_in;
                s1_p     <= p_in;
                s1_g     <= g_in;
                s1_gp    <= gp_in;
                s1_gg    <= gg_in;
            end
        end
    end

    // Stage-2 combinational: lookahead group carries, then in-group ripple
    logic             cin_eff;
    logic [NGRP-1:0]  grp_c;
    logic [WIDTH-1:0] bit_c, sum_d;
    logic             ovf_d;

    assign cin_eff = s1_chain ? carry_reg : (s1_sub ? 1'b1 : s1_cin);

    cla_lookahead_tree #(
        .NGRP(NGRP)
    ) u_tree (
        .p  (s1_gp),
        .g  (s1_gg),
        .cin(cin_eff),
        .c  (grp_c)
    );

    always_comb begin
        logic c;
        bit_c = '0;
        c     = cin_eff;
        for (int unsigned k = 0; k < NGRP; k++) begin
            for (int unsigned i = 0; i < GROUP; i++) begin
                bit_c[k*GROUP+i] = c;
                c = s1_g[k*GROUP+i] | (s1_p[k*GROUP+i] & c);
            end
            c = grp_c[k];
        end
    end

    assign sum_d = s1_a ^ s1_b ^ bit_c;
    assign ovf_d = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum_d[WIDTH-1] != s1_a[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_gc    <= '0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum  <= sum_d;
                out_cout <= grp_c[NGRP-1];
                out_ovf  <= ovf_d;
                out_gc   <= grp_c;
            end
        end
    end

    // A clear landing with a stage-2 update wins; that word already used the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_reg <= 1'b0;
        end else if (clr_carry) begin
            carry_reg <= 1'b0;
        end else if (s2_en && s1_valid) begin
            carry_reg <= grp_c[NGRP-1];
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed self-checking bench for cla_pipe_adder (32/4 main instance,
// 16/8 secondary instance).
module tb_cla_pipe_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_sub, in_cin, in_chain, clr_carry;
    logic [31:0] in_a, in_b, out_sum;
    logic        out_valid, out_ready, out_cout, out_ovf;
    logic [7:0]  out_gc;

    logic        v16_in_valid, v16_in_ready, v16_in_sub, v16_in_cin;
    logic [15:0] v16_in_a, v16_in_b, v16_out_sum;
    logic        v16_out_valid, v16_out_cout, v16_out_ovf;
    logic [1:0]  v16_out_gc;
    logic        v16_chain, v16_clr, v16_out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(32), .GROUP(4)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sub   (in_sub),
        .in_cin   (in_cin),
        .in_chain (in_chain),
        .clr_carry(clr_carry),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf),
        .out_gc   (out_gc)
    );

    cla_pipe_adder #(.WIDTH(16), .GROUP(8)) u_dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (v16_in_valid),
        .in_ready (v16_in_ready),
        .in_a     (v16_in_a),
        .in_b     (v16_in_b),
        .in_sub   (v16_in_sub),
        .in_cin   (v16_in_cin),
        .in_chain (v16_chain),
        .clr_carry(v16_clr),
        .out_valid(v16_out_valid),
        .out_ready(v16_out_ready),
        .out_sum  (v16_out_sum),
        .out_cout (v16_out_cout),
        .out_ovf  (v16_out_ovf),
        .out_gc   (v16_out_gc)
    );

    localparam logic [15:0] V16_A   [4] = '{16'hFFFF, 16'h1234, 16'h8000, 16'h0005};
    localparam logic [15:0] V16_B   [4] = '{16'h0001, 16'h4321, 16'h8000, 16'h0007};
    localparam logic        V16_SUB [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic        V16_CIN [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [15:0] V16_SUM [4] = '{16'h0000, 16'h5556, 16'h0000, 16'hFFFE};
    localparam logic        V16_CO  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic cin, input logic chain);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_cin   = cin;
        in_chain = chain;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_sum !== 32'h0) begin n_fail++; $display("FAIL reset_sum: got %h expected 0", out_sum); end
        n_checks++; if (out_gc !== 8'h0) begin n_fail++; $display("FAIL reset_gc: got %h expected 0", out_gc); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        drive(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_latency: got %b expected 0", out_valid); end
        step();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_sum !== 32'h0) begin n_fail++; $display("FAIL add_sum: got %h expected 0", out_sum); end
        n_checks++; if (out_cout !== 1'b1) begin n_fail++; $display("FAIL add_cout: got %b expected 1", out_cout); end
        n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL add_ovf: got %b expected 0", out_ovf); end
        n_checks++; if (out_gc !== 8'hFF) begin n_fail++; $display("FAIL add_gc: got %h expected ff", out_gc); end
        drive(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        step();
        drive(32'h1, 32'h2, 1'b0, 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
        n_checks++; if (out_sum !== 32'h8000_0000) begin n_fail++; $display("FAIL add_pos_sum: got %h expected 80000000", out_sum); end
        n_checks++; if (out_ovf !== 1'b1) begin n_fail++; $display("FAIL add_pos_ovf: got %b expected 1", out_ovf); end
        n_checks++; if (out_gc !== 8'h7F) begin n_fail++; $display("FAIL add_pos_gc: got %h expected 7f", out_gc); end
        step();
        n_checks++; if (out_sum !== 32'h4) begin n_fail++; $display("FAIL add_cin_sum: got %h expected 4", out_sum); end
        n_checks++; if (out_cout !== 1'b0) begin n_fail++; $display("FAIL add_cin_cout: got %b expected 0", out_cout); end
        step();
    endtask

    task automatic test_sub();
        drive(32'h5, 32'h7, 1'b1, 1'b0, 1'b0);
        step();
        drive(32'h8000_0000, 32'h1, 1'b1, 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
        n_checks++; if (out_sum !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_sum: got %h expected fffffffe", out_sum); end
        n_checks++; if (out_cout !== 1'b0) begin n_fail++; $display("FAIL sub_borrow: got %b expected 0", out_cout); end
        n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL sub_ovf: got %b expected 0", out_ovf); end
        step();
        n_checks++; if (out_sum !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sub_min_sum: got %h expected 7fffffff", out_sum); end
        n_checks++; if (out_cout !== 1'b1) begin n_fail++; $display("FAIL sub_min_cout: got %b expected 1", out_cout); end
        n_checks++; if (out_ovf !== 1'b1) begin n_fail++; $display("FAIL sub_min_ovf: got %b expected 1", out_ovf); end
        step();
    endtask

    task automatic test_chain();
        drive(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        step();
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        n_checks++; if (out_sum !== 32'h0) begin n_fail++; $display("FAIL chain_lo: got %h expected 0", out_sum); end
        step();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL chain_hi_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_sum !== 32'h1) begin n_fail++; $display("FAIL chain_hi: got %h expected 1", out_sum); end
        step();
    endtask

    task automatic test_clr_carry();
        drive(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        step();
        drive(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        n_checks++; if (out_cout !== 1'b1) begin n_fail++; $display("FAIL clr_setup_cout: got %b expected 1", out_cout); end
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        clr_carry = 1'b1;
        step();
        clr_carry = 1'b0;
        in_valid  = 1'b0;
        n_checks++; if (out_sum !== 32'h0) begin n_fail++; $display("FAIL clr_old_sum: got %h expected 0", out_sum); end
        n_checks++; if (out_cout !== 1'b1) begin n_fail++; $display("FAIL clr_old_cout: got %b expected 1", out_cout); end
        step();
        n_checks++; if (out_sum !== 32'h0) begin n_fail++; $display("FAIL clr_new_sum: got %h expected 0", out_sum); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_new_valid: got %b expected 1", out_valid); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_sum [5];
        int   sent = 0;
        int   recv = 0;
        logic stall_prev = 1'b0;
        logic [31:0] prev_sum = '0;
        logic acc_in, acc_out;
        for (int i = 0; i < 5; i++) exp_sum[i] = (32'h1111_1111 * i) + 32'h1;
        for (int cyc = 1; cyc <= 40 && recv < 5; cyc++) begin
            in_valid  = (sent < 5);
            in_a      = 32'h1111_1111 * sent;
            in_b      = 32'h1;
            in_sub    = 1'b0;
            in_cin    = 1'b0;
            in_chain  = 1'b0;
            out_ready = !(cyc >= 3 && cyc <= 6);
            #1;
            if (cyc == 4) begin
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
            end
            if (stall_prev) begin
                n_checks++; if (out_valid !== 1'b1 || out_sum !== prev_sum) begin
                    n_fail++; $display("FAIL bp_stable: got %b/%h expected 1/%h", out_valid, out_sum, prev_sum);
                end
            end
            acc_in  = in_valid && in_ready;
            acc_out = out_valid && out_ready;
            if (acc_out) begin
                n_checks++; if (out_sum !== exp_sum[recv]) begin
                    n_fail++; $display("FAIL bp_word%0d: got %h expected %h", recv, out_sum, exp_sum[recv]);
                end
                recv++;
            end
            stall_prev = out_valid && !out_ready;
            prev_sum   = out_sum;
            step();
            if (acc_in) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++; if (recv != 5) begin n_fail++; $display("FAIL bp_count: got %0d expected 5", recv); end
        step();
    endtask

    task automatic test_reset_inflight();
        drive(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        step();
        drive(32'h3, 32'h4, 1'b0, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_sum !== 32'h0) begin n_fail++; $display("FAIL rst_sum: got %h expected 0", out_sum); end
        n_checks++; if (out_cout !== 1'b0) begin n_fail++; $display("FAIL rst_cout: got %b expected 0", out_cout); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ghost: got %b expected 0", out_valid); end
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_first_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_sum !== 32'h0) begin n_fail++; $display("FAIL rst_carry_cleared: got %h expected 0", out_sum); end
        step();
    endtask

    task automatic test_width16();
        for (int i = 0; i < 4; i++) begin
            v16_in_valid = 1'b1;
            v16_in_a     = V16_A[i];
            v16_in_b     = V16_B[i];
            v16_in_sub   = V16_SUB[i];
            v16_in_cin   = V16_CIN[i];
            step();
            v16_in_valid = 1'b0;
            step();
            n_checks++; if (v16_out_valid !== 1'b1 || v16_out_sum !== V16_SUM[i]) begin
                n_fail++; $display("FAIL w16_sum%0d: got %b/%h expected 1/%h", i, v16_out_valid, v16_out_sum, V16_SUM[i]);
            end
            n_checks++; if (v16_out_cout !== V16_CO[i]) begin
                n_fail++; $display("FAIL w16_cout%0d: got %b expected %b", i, v16_out_cout, V16_CO[i]);
            end
            if (i == 0) begin
                n_checks++; if (v16_out_gc !== 2'b11) begin n_fail++; $display("FAIL w16_gc: got %b expected 11", v16_out_gc); end
            end
            if (i == 2) begin
                n_checks++; if (v16_out_ovf !== 1'b1) begin n_fail++; $display("FAIL w16_ovf: got %b expected 1", v16_out_ovf); end
            end
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_a          = '0;
        in_b          = '0;
        in_sub        = 1'b0;
        in_cin        = 1'b0;
        in_chain      = 1'b0;
        clr_carry     = 1'b0;
        out_ready     = 1'b1;
        v16_in_valid  = 1'b0;
        v16_in_a      = '0;
        v16_in_b      = '0;
        v16_in_sub    = 1'b0;
        v16_in_cin    = 1'b0;
        v16_chain     = 1'b0;
        v16_clr       = 1'b0;
        v16_out_ready = 1'b1;
        test_reset();
        test_add();
        test_sub();
        test_chain();
        test_clr_carry();
        test_back_to_back();
        test_reset_inflight();
        test_width16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
